// File: rtl/ni_packet_bridge.sv
// Network interface bridge: packetises TX words into head/body/tail flits through a
// show-ahead flit FIFO, and de-packetises RX flits into words with source, last and error.
module ni_packet_bridge #(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 8,
    parameter int                FLIT_W     = 48,
    parameter int                BURST      = 4,
    parameter int                FIFO_DEPTH = 8,
    parameter logic [ADDR_W-1:0] SRC_ID     = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_W-1:0]               tx_data,
    input  logic [ADDR_W-1:0]               tx_dest,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic [FLIT_W-1:0]               flit_out,
    output logic                            flit_out_valid,
    input  logic                            flit_out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    input  logic [FLIT_W-1:0]               flit_in,
    input  logic                            flit_in_valid,
    output logic                            flit_in_ready,
    output logic [DATA_W-1:0]               rx_data,
    output logic [ADDR_W-1:0]               rx_src,
    output logic                            rx_valid,
    output logic                            rx_last,
    input  logic                            rx_ready,
    output logic                            rx_err
);

    localparam int         PAY_W   = FLIT_W - 2;
    localparam int         PTR_W   = $clog2(FIFO_DEPTH);
    localparam int         LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0] TX_LEN  = 8'(BURST);
    localparam logic [7:0] TX_LAST = 8'(BURST - 1);

    typedef enum logic [1:0] {FT_INV = 2'b00, FT_HEAD = 2'b01, FT_BODY = 2'b10, FT_TAIL = 2'b11} flit_type_e;
    typedef enum logic [1:0] {T_IDLE, T_HEAD, T_BODY, T_TAIL} tx_state_e;
    typedef enum logic [1:0] {R_HEAD, R_BODY, R_TAIL} rx_state_e;
    typedef logic [PAY_W-1:0] payload_t;

    // ---------------- TX packetiser ----------------
    tx_state_e         tx_state_q, tx_state_d;
    logic [ADDR_W-1:0] tx_dest_q, tx_dest_d;
    logic [7:0]        tx_cnt_q, tx_cnt_d;
    logic [DATA_W-1:0] tx_csum_q, tx_csum_d;
    logic              push_req, push_en, pop_en, fifo_full;
    logic [FLIT_W-1:0] push_flit;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= T_IDLE;
            tx_dest_q  <= '0;
            tx_cnt_q   <= '0;
            tx_csum_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_dest_q  <= tx_dest_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_csum_q  <= tx_csum_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_dest_d  = tx_dest_q;
        tx_cnt_d   = tx_cnt_q;
        tx_csum_d  = tx_csum_q;
        case (tx_state_q)
            T_IDLE: if (tx_valid) begin
                tx_dest_d  = tx_dest;
                tx_state_d = T_HEAD;
            end
            T_HEAD: if (!fifo_full) begin
                tx_cnt_d   = '0;
                tx_csum_d  = '0;
                tx_state_d = T_BODY;
            end
            T_BODY: if (tx_valid && !fifo_full) begin
                tx_csum_d = tx_csum_q ^ tx_data;
                tx_cnt_d  = tx_cnt_q + 8'd1;
                if (tx_cnt_q == TX_LAST) tx_state_d = T_TAIL;
            end
            T_TAIL: if (!fifo_full) tx_state_d = T_IDLE;
            default: tx_state_d = T_IDLE;
        endcase
    end

    always_comb begin
        tx_ready  = 1'b0;
        push_req  = 1'b0;
        push_flit = '0;
        case (tx_state_q)
            T_HEAD: begin
                push_req  = 1'b1;
                push_flit = {FT_HEAD, payload_t'({SRC_ID, tx_dest_q, TX_LEN})};
            end
            T_BODY: begin
                tx_ready  = !fifo_full;
                push_req  = tx_valid;
                push_flit = {FT_BODY, payload_t'(tx_data)};
            end
            T_TAIL: begin
                push_req  = 1'b1;
                push_flit = {FT_TAIL, payload_t'(tx_csum_q)};
            end
            default: ;
        endcase
    end

    // ---------------- TX flit FIFO (show-ahead) ----------------
    logic [FLIT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q;

    assign fifo_full      = (level_q == LVL_W'(FIFO_DEPTH));
    assign flit_out_valid = (level_q != '0);
    assign flit_out       = fifo_mem[rd_ptr_q];
    assign fifo_level     = level_q;
    // A pop cannot make room for a same-cycle write: full blocks the write regardless.
    assign push_en        = push_req && !fifo_full;
    assign pop_en         = flit_out_valid && flit_out_ready;

    // NOTE: storage carries no reset; only pointers and level are reset, and level qualifies the data.
    always_ff @(posedge clk) begin
        if (push_en) fifo_mem[wr_ptr_q] <= push_flit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_en, pop_en})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: ;
            endcase
        end
    end

    // ---------------- RX de-packetiser ----------------
    rx_state_e         rx_state_q, rx_state_d;
    logic [ADDR_W-1:0] rx_src_q, rx_src_d;
    logic [7:0]        rx_len_q, rx_len_d, rx_cnt_q, rx_cnt_d;
    logic [DATA_W-1:0] rx_csum_q, rx_csum_d, rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d, rx_last_q, rx_last_d, rx_err_q, rx_err_d;
    logic              rx_take, rx_unused;
    flit_type_e        in_type;
    payload_t          in_pay;

    assign in_type   = flit_type_e'(flit_in[FLIT_W-1 -: 2]);
    assign in_pay    = flit_in[PAY_W-1:0];
    assign rx_take   = flit_in_valid && flit_in_ready;
    assign rx_unused = ^in_pay;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= R_HEAD;
            rx_src_q   <= '0;
            rx_len_q   <= '0;
            rx_cnt_q   <= '0;
            rx_csum_q  <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_last_q  <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_src_q   <= rx_src_d;
            rx_len_q   <= rx_len_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_csum_q  <= rx_csum_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_last_q  <= rx_last_d;
            rx_err_q   <= rx_err_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_src_d   = rx_src_q;
        rx_len_d   = rx_len_q;
        rx_cnt_d   = rx_cnt_q;
        rx_csum_d  = rx_csum_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q && !rx_ready;
        rx_last_d  = rx_last_q;
        rx_err_d   = 1'b0;
        if (rx_take) begin
            case (rx_state_q)
                R_HEAD: if (in_type == FT_HEAD) begin
                    rx_src_d   = in_pay[2*ADDR_W+7 -: ADDR_W];
                    rx_len_d   = in_pay[7:0];
                    rx_cnt_d   = '0;
                    rx_csum_d  = '0;
                    rx_state_d = (in_pay[7:0] == 8'd0) ? R_TAIL : R_BODY;
                end else begin
                    rx_err_d = 1'b1;
                end
                R_BODY: if (in_type == FT_BODY) begin
                    rx_data_d  = in_pay[DATA_W-1:0];
                    rx_valid_d = 1'b1;
                    rx_csum_d  = rx_csum_q ^ in_pay[DATA_W-1:0];
                    rx_cnt_d   = rx_cnt_q + 8'd1;
                    rx_last_d  = ((rx_cnt_q + 8'd1) == rx_len_q);
                    if ((rx_cnt_q + 8'd1) == rx_len_q) rx_state_d = R_TAIL;
                end else begin
                    rx_err_d   = 1'b1;
                    rx_state_d = R_HEAD;
                end
                R_TAIL: begin
                    rx_err_d   = (in_type != FT_TAIL) || (in_pay[DATA_W-1:0] != rx_csum_q);
                    rx_state_d = R_HEAD;
                end
                default: rx_state_d = R_HEAD;
            endcase
        end
    end

    always_comb begin
        flit_in_ready = !rx_valid_q || rx_ready;
        rx_data       = rx_data_q;
        rx_src        = rx_src_q;
        rx_valid      = rx_valid_q;
        rx_last       = rx_last_q;
        rx_err        = rx_err_q;
    end

endmodule

// File: tb/tb_ni_packet_bridge.sv
// Scoreboard bench for ni_packet_bridge: directed TX and RX packets with hand-computed flits/words.
module tb_ni_packet_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] tx_data;
    logic [7:0]  tx_dest;
    logic        tx_valid, tx_ready;
    logic [47:0] flit_out;
    logic        flit_out_valid, flit_out_ready;
    logic [3:0]  fifo_level;
    logic [47:0] flit_in;
    logic        flit_in_valid, flit_in_ready;
    logic [15:0] rx_data;
    logic [7:0]  rx_src;
    logic        rx_valid, rx_last, rx_ready, rx_err;

    always #5 clk = ~clk;

    ni_packet_bridge #(
        .DATA_W(16), .ADDR_W(8), .FLIT_W(48), .BURST(4), .FIFO_DEPTH(8), .SRC_ID(8'h00)
    ) dut (
        .clk(clk), .reset(reset),
        .tx_data(tx_data), .tx_dest(tx_dest), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .flit_out(flit_out), .flit_out_valid(flit_out_valid), .flit_out_ready(flit_out_ready),
        .fifo_level(fifo_level),
        .flit_in(flit_in), .flit_in_valid(flit_in_valid), .flit_in_ready(flit_in_ready),
        .rx_data(rx_data), .rx_src(rx_src), .rx_valid(rx_valid), .rx_last(rx_last),
        .rx_ready(rx_ready), .rx_err(rx_err)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  src;
        logic        last;
    } rx_exp_t;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          err_seen = 0;
    logic [47:0] exp_flit_q [$];
    rx_exp_t     exp_rx_q [$];
    bit          tx_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Monitor: compares every flit popped and every word consumed against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (flit_out_valid && flit_out_ready) begin
                if (exp_flit_q.size() == 0) timeout_fail("unexpected tx flit");
                else check("tx flit", flit_out, exp_flit_q.pop_front());
            end
            if (rx_valid && rx_ready) begin
                if (exp_rx_q.size() == 0) timeout_fail("unexpected rx word");
                else check("rx word {data,src,last}", {rx_data, rx_src, rx_last}, exp_rx_q.pop_front());
            end
            if (rx_err) err_seen++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_packet(input logic [7:0] dest, input logic [15:0] w [4]);
        for (int i = 0; i < 4; i++) begin
            int k = 0;
            tx_dest  = dest;
            tx_data  = w[i];
            tx_valid = 1'b1;
            forever begin
                @(negedge clk);
                if (tx_ready) break;
                if (++k > 300) begin timeout_fail("tx handshake"); break; end
            end
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
    endtask

    task automatic send_flit(input logic [47:0] f);
        int k = 0;
        flit_in       = f;
        flit_in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (flit_in_ready) break;
            if (++k > 300) begin timeout_fail("rx flit handshake"); break; end
        end
        @(posedge clk); #1;
        flit_in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_flit_q.size() != 0 || exp_rx_q.size() != 0) begin
            @(negedge clk);
            if (++k > 500) begin timeout_fail(name); break; end
        end
        cycles(3);
    endtask

    int e0;

    initial begin
        reset = 1'b0; tx_data = '0; tx_dest = '0; tx_valid = 1'b0; flit_out_ready = 1'b0;
        flit_in = '0; flit_in_valid = 1'b0; rx_ready = 1'b0;
        cycles(2);
        check("reset tx_ready", tx_ready, 0);
        check("reset flit_out_valid", flit_out_valid, 0);
        check("reset fifo_level", fifo_level, 0);
        check("reset flit_in_ready", flit_in_ready, 1);
        check("reset rx_valid/last/err", {rx_valid, rx_last, rx_err}, 0);
        check("reset rx_data/src", {rx_data, rx_src}, 0);
        reset = 1'b1;
        cycles(1);

        // T1: reset mid-BODY with 3 flits queued
        tx_dest = 8'h05; tx_data = 16'h0001; tx_valid = 1'b1;
        begin
            int k = 0;
            forever begin
                @(negedge clk);
                if (fifo_level == 4'd3) break;
                if (++k > 20) begin timeout_fail("T1 fill to 3"); break; end
            end
        end
        reset = 1'b0;
        #1;
        check("T1 fifo_level", fifo_level, 0);
        check("T1 flit_out_valid", flit_out_valid, 0);
        check("T1 tx_ready", tx_ready, 0);
        check("T1 rx_valid", rx_valid, 0);
        tx_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        cycles(3);
        check("T1 level after release", fifo_level, 0);

        // T2: one packet to dest 05
        flit_out_ready = 1'b1;
        exp_flit_q.push_back(48'h4000_0000_0504);
        exp_flit_q.push_back(48'h8000_0000_0001);
        exp_flit_q.push_back(48'h8000_0000_0002);
        exp_flit_q.push_back(48'h8000_0000_0004);
        exp_flit_q.push_back(48'h8000_0000_0008);
        exp_flit_q.push_back(48'hC000_0000_000F);
        send_packet(8'h05, '{16'h0001, 16'h0002, 16'h0004, 16'h0008});
        drain("T2 drain");
        check("T2 fifo empty", {flit_out_valid, fifo_level}, 0);

        // T3: stall the link with two packets queued
        @(posedge clk); #1;
        flit_out_ready = 1'b0;
        exp_flit_q.push_back(48'h4000_0000_0504);
        exp_flit_q.push_back(48'h8000_0000_1111);
        exp_flit_q.push_back(48'h8000_0000_2222);
        exp_flit_q.push_back(48'h8000_0000_4444);
        exp_flit_q.push_back(48'h8000_0000_8888);
        exp_flit_q.push_back(48'hC000_0000_FFFF);
        exp_flit_q.push_back(48'h4000_0000_0A04);
        exp_flit_q.push_back(48'h8000_0000_00FF);
        exp_flit_q.push_back(48'h8000_0000_0F0F);
        exp_flit_q.push_back(48'h8000_0000_3333);
        exp_flit_q.push_back(48'h8000_0000_5555);
        exp_flit_q.push_back(48'hC000_0000_6996);
        tx_done = 1'b0;
        fork
            begin
                send_packet(8'h05, '{16'h1111, 16'h2222, 16'h4444, 16'h8888});
                send_packet(8'h0A, '{16'h00FF, 16'h0F0F, 16'h3333, 16'h5555});
                tx_done = 1'b1;
            end
        join_none
        begin
            int k = 0;
            forever begin
                @(negedge clk);
                if (fifo_level == 4'd8) break;
                if (++k > 100) begin timeout_fail("T3 fill to 8"); break; end
            end
        end
        repeat (3) @(negedge clk);
        check("T3 fifo_level full", fifo_level, 8);
        check("T3 tx_ready while full", tx_ready, 0);
        check("T3 flit_out_valid", flit_out_valid, 1);
        check("T3 nothing popped", exp_flit_q.size(), 12);
        @(posedge clk); #1;
        flit_out_ready = 1'b1;
        drain("T3 drain");
        begin
            int k = 0;
            while (!tx_done) begin
                @(negedge clk);
                if (++k > 100) begin timeout_fail("T3 tx done"); break; end
            end
        end
        check("T3 fifo_level after drain", fifo_level, 0);

        // T4: receive the T2 packet
        rx_ready = 1'b1;
        e0 = err_seen;
        exp_rx_q.push_back('{16'h0001, 8'h00, 1'b0});
        exp_rx_q.push_back('{16'h0002, 8'h00, 1'b0});
        exp_rx_q.push_back('{16'h0004, 8'h00, 1'b0});
        exp_rx_q.push_back('{16'h0008, 8'h00, 1'b1});
        send_flit(48'h4000_0000_0504);
        send_flit(48'h8000_0000_0001);
        send_flit(48'h8000_0000_0002);
        send_flit(48'h8000_0000_0004);
        send_flit(48'h8000_0000_0008);
        send_flit(48'hC000_0000_000F);
        drain("T4 drain");
        check("T4 rx_err pulses", err_seen - e0, 0);

        // T5: bad checksum, then a clean packet from node 3C
        e0 = err_seen;
        exp_rx_q.push_back('{16'h0001, 8'h00, 1'b0});
        exp_rx_q.push_back('{16'h0002, 8'h00, 1'b0});
        exp_rx_q.push_back('{16'h0004, 8'h00, 1'b0});
        exp_rx_q.push_back('{16'h0008, 8'h00, 1'b1});
        send_flit(48'h4000_0000_0504);
        send_flit(48'h8000_0000_0001);
        send_flit(48'h8000_0000_0002);
        send_flit(48'h8000_0000_0004);
        send_flit(48'h8000_0000_0008);
        send_flit(48'hC000_0000_000E);
        drain("T5 drain bad");
        check("T5 bad tail rx_err pulses", err_seen - e0, 1);
        e0 = err_seen;
        exp_rx_q.push_back('{16'h0010, 8'h3C, 1'b0});
        exp_rx_q.push_back('{16'h0200, 8'h3C, 1'b0});
        exp_rx_q.push_back('{16'h3000, 8'h3C, 1'b0});
        exp_rx_q.push_back('{16'h0004, 8'h3C, 1'b1});
        send_flit(48'h4000_003C_0004);
        send_flit(48'h8000_0000_0010);
        send_flit(48'h8000_0000_0200);
        send_flit(48'h8000_0000_3000);
        send_flit(48'h8000_0000_0004);
        send_flit(48'hC000_0000_3214);
        drain("T5 drain clean");
        check("T5 clean packet rx_err pulses", err_seen - e0, 0);

        // T6: early tail, then backpressure on the next packet
        e0 = err_seen;
        exp_rx_q.push_back('{16'h0001, 8'h00, 1'b0});
        exp_rx_q.push_back('{16'h0002, 8'h00, 1'b0});
        send_flit(48'h4000_0000_0504);
        send_flit(48'h8000_0000_0001);
        send_flit(48'h8000_0000_0002);
        send_flit(48'hC000_0000_0003);
        drain("T6 drain early tail");
        check("T6 early tail rx_err pulses", err_seen - e0, 1);
        e0 = err_seen;
        rx_ready = 1'b0;
        send_flit(48'h4000_003C_0004);
        send_flit(48'h8000_0000_0055);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("T6 hold {valid,data,src,last}", {rx_valid, rx_data, rx_src, rx_last}, {1'b1, 16'h0055, 8'h3C, 1'b0});
            check("T6 hold flit_in_ready", flit_in_ready, 0);
        end
        exp_rx_q.push_back('{16'h0055, 8'h3C, 1'b0});
        @(posedge clk); #1;
        rx_ready = 1'b1;
        exp_rx_q.push_back('{16'h00AA, 8'h3C, 1'b0});
        exp_rx_q.push_back('{16'h0001, 8'h3C, 1'b0});
        exp_rx_q.push_back('{16'h0002, 8'h3C, 1'b1});
        send_flit(48'h8000_0000_00AA);
        send_flit(48'h8000_0000_0001);
        send_flit(48'h8000_0000_0002);
        send_flit(48'hC000_0000_00FC);
        drain("T6 drain after hold");
        check("T6 recovery rx_err pulses", err_seen - e0, 0);

        check("tx scoreboard empty", exp_flit_q.size(), 0);
        check("rx scoreboard empty", exp_rx_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
